// File: rtl/weight_fetch_pkg.sv
// rtl/weight_fetch_pkg.sv - shared types and constants for the weight fetch arbiter
// State encoding, pipeline constants and id-width helper.
package weight_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BURST = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int ROM_RD_LAT = 1;
   // ROM register plus the response output register.
   localparam int PIPE_DEPTH = ROM_RD_LAT + 1;

   function automatic int id_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/weight_fetch_arbiter_rr_arbiter.sv
// rtl/weight_fetch_arbiter_rr_arbiter.sv - combinational round-robin picker
// Grants the first set request at or after the pointer, wrapping around.
import weight_fetch_pkg::*;

module rr_arbiter #(
   parameter int  NUM_REQ = 4,
   localparam int IW      = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IW-1:0]      o_gnt_idx,
   output logic               o_gnt_valid
);

   logic [IW-1:0] w_j;

   always_comb begin
      o_gnt       = '0;
      o_gnt_idx   = '0;
      o_gnt_valid = 1'b0;
      w_j         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_j = IW'((int'(i_ptr) + i) % NUM_REQ);
         if (!o_gnt_valid && i_req[w_j]) begin
            o_gnt_valid = 1'b1;
            o_gnt[w_j]  = 1'b1;
            o_gnt_idx   = w_j;
         end
      end
   end

endmodule

// File: rtl/weight_fetch_arbiter.sv
// rtl/weight_fetch_arbiter.sv - round-robin burst arbiter sharing one weight ROM
// Optional sticky wrap_err output enabled by defining WEIGHT_FETCH_WRAP_ERR_EN.
import weight_fetch_pkg::*;

module weight_fetch_arbiter #(
   parameter int  NUM_REQ    = 4,
   parameter int  ADDR_WIDTH = 10,
   parameter int  DATA_WIDTH = 32,
   parameter int  LEN_WIDTH  = 8,
   localparam int IW         = id_width(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   input  logic signed [DATA_WIDTH-1:0]  rom_data,
   output logic                          rsp_valid,
   output logic signed [DATA_WIDTH-1:0]  rsp_data,
   output logic [IW-1:0]                 rsp_id,
   output logic                          rsp_last,
   output logic                          busy
`ifdef WEIGHT_FETCH_WRAP_ERR_EN
   ,
   output logic                          wrap_err
`endif
);

   state_t                       r_state;
   state_t                       w_next;
   logic [IW-1:0]                r_ptr;
   logic [IW-1:0]                r_gnt_idx;
   logic [IW-1:0]                r_rsp_id;
   logic [IW-1:0]                w_arb_idx;
   logic [NUM_REQ-1:0]           r_req_ready;
   logic [NUM_REQ-1:0]           w_arb_gnt;
   logic                         w_arb_valid;
   logic [ADDR_WIDTH-1:0]        r_rom_addr;
   logic [ADDR_WIDTH-1:0]        w_sel_base;
   logic [LEN_WIDTH-1:0]         r_cnt;
   logic [LEN_WIDTH-1:0]         w_sel_len;
   logic [PIPE_DEPTH-1:0]        r_vld_sr;
   logic [PIPE_DEPTH-1:0]        r_last_sr;
   logic signed [DATA_WIDTH-1:0] r_rsp_data;
   logic                         w_issue;
   logic                         w_issue_last;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .i_req       (req_valid),
      .i_ptr       (r_ptr),
      .o_gnt       (w_arb_gnt),
      .o_gnt_idx   (w_arb_idx),
      .o_gnt_valid (w_arb_valid)
   );

   assign w_sel_base   = req_base[r_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_sel_len    = req_len[r_gnt_idx*LEN_WIDTH +: LEN_WIDTH];
   assign w_issue      = (r_state == BURST);
   assign w_issue_last = w_issue && (r_cnt == LEN_WIDTH'(1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_arb_valid) w_next = GRANT;
         GRANT:   w_next = (w_sel_len == '0) ? IDLE : BURST;
         BURST:   if (r_cnt == LEN_WIDTH'(1)) w_next = DRAIN;
         DRAIN:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_gnt_idx   <= '0;
         r_rsp_id    <= '0;
         r_req_ready <= '0;
         r_rom_addr  <= '0;
         r_cnt       <= '0;
         r_vld_sr    <= '0;
         r_last_sr   <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_req_ready <= '0;
         case (r_state)
            IDLE: begin
               if (w_arb_valid) begin
                  r_gnt_idx   <= w_arb_idx;
                  r_req_ready <= w_arb_gnt;
               end
            end
            GRANT: begin
               r_ptr    <= (r_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IW'(1);
               r_rsp_id <= r_gnt_idx;
               if (w_sel_len != '0) begin
                  r_rom_addr <= w_sel_base;
                  r_cnt      <= w_sel_len;
               end
            end
            BURST: begin
               // Hold the final address so it stays on the bus through DRAIN.
               if (r_cnt != LEN_WIDTH'(1)) begin
                  r_rom_addr <= r_rom_addr + ADDR_WIDTH'(1);
                  r_cnt      <= r_cnt - LEN_WIDTH'(1);
               end
            end
            default: ;
         endcase
         r_vld_sr   <= {r_vld_sr[PIPE_DEPTH-2:0], w_issue};
         r_last_sr  <= {r_last_sr[PIPE_DEPTH-2:0], w_issue_last};
         r_rsp_data <= rom_data;
      end
   end

`ifdef WEIGHT_FETCH_WRAP_ERR_EN
   logic [ADDR_WIDTH:0] w_end;
   logic                r_wrap_err;

   assign w_end = {1'b0, w_sel_base} + (ADDR_WIDTH+1)'(w_sel_len);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_wrap_err <= 1'b0;
      else if (r_state == GRANT && w_end > {1'b1, {ADDR_WIDTH{1'b0}}})
         r_wrap_err <= 1'b1;
   end

   assign wrap_err = r_wrap_err;
`endif

   assign req_ready = r_req_ready;
   assign rom_addr  = r_rom_addr;
   assign rsp_valid = r_vld_sr[PIPE_DEPTH-1];
   assign rsp_last  = r_last_sr[PIPE_DEPTH-1];
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// tb/tb_weight_fetch_arbiter.sv - directed self-checking bench for weight_fetch_arbiter
// Checks wrap_err as well when WEIGHT_FETCH_WRAP_ERR_EN is defined.
module tb_weight_fetch_arbiter;

   localparam int NR = 4;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int IW = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NR-1:0]        req_valid;
   logic [NR-1:0]        req_ready;
   logic [NR*AW-1:0]     req_base;
   logic [NR*LW-1:0]     req_len;
   logic [AW-1:0]        rom_addr;
   logic signed [DW-1:0] rom_data;
   logic                 rsp_valid;
   logic signed [DW-1:0] rsp_data;
   logic [IW-1:0]        rsp_id;
   logic                 rsp_last;
   logic                 busy;
`ifdef WEIGHT_FETCH_WRAP_ERR_EN
   logic                 wrap_err;
   logic                 wrap_log [int];
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int busy_cnt     = 0;
   int gnt_q[$];
   int gnt_cyc[$];
   int beat_cyc[$];
   logic [DW-1:0] beat_data[$];
   logic [IW-1:0] beat_id[$];
   logic          beat_last[$];
   logic [AW-1:0] addr_log [int];

   weight_fetch_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_base  (req_base),
      .req_len   (req_len),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_last  (rsp_last),
      .busy      (busy)
`ifdef WEIGHT_FETCH_WRAP_ERR_EN
      ,
      .wrap_err  (wrap_err)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return {6'h2A, a, ~a, 6'h15};
   endfunction

   always @(posedge clk) rom_data <= rom_f(rom_addr);

   task automatic clear_logs();
      gnt_q.delete(); gnt_cyc.delete(); beat_cyc.delete();
      beat_data.delete(); beat_id.delete(); beat_last.delete();
      addr_log.delete();
`ifdef WEIGHT_FETCH_WRAP_ERR_EN
      wrap_log.delete();
`endif
      busy_cnt = 0;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] b, input logic [LW-1:0] l);
      req_base[i*AW +: AW] = b;
      req_len[i*LW +: LW]  = l;
      req_valid[i]         = 1'b1;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      addr_log[cyc] = rom_addr;
`ifdef WEIGHT_FETCH_WRAP_ERR_EN
      wrap_log[cyc] = wrap_err;
`endif
      for (int i = 0; i < NR; i++)
         if (req_ready[i]) begin gnt_q.push_back(i); gnt_cyc.push_back(cyc); end
      req_valid = req_valid & ~req_ready;
      if (rsp_valid) begin
         beat_data.push_back(rsp_data); beat_id.push_back(rsp_id);
         beat_last.push_back(rsp_last); beat_cyc.push_back(cyc);
      end
      if (busy) busy_cnt++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '0; req_base = '0; req_len = '0;
      repeat (2) @(negedge clk);
      tests_run++; if (req_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      tests_run++; if (rsp_last !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_last got %b exp 0", rsp_last); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests_run++; if (rom_addr !== '0) begin tests_failed++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
      tests_run++; if (rsp_id !== '0) begin tests_failed++; $display("FAIL reset_rsp_id got %h exp 0", rsp_id); end
      tests_run++; if (rsp_data !== '0) begin tests_failed++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
`ifdef WEIGHT_FETCH_WRAP_ERR_EN
      tests_run++; if (wrap_err !== 1'b0) begin tests_failed++; $display("FAIL reset_wrap_err got %b exp 0", wrap_err); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int g;
      logic [AW-1:0] ea;
      clear_logs();
      set_req(0, 10'h010, 8'd4);
      repeat (16) step();
      tests_run++; if (gnt_q.size() !== 1) begin tests_failed++; $display("FAIL single_grants got %0d exp 1", gnt_q.size()); end
      if (gnt_q.size() == 1) begin
         g = gnt_cyc[0];
         tests_run++; if (gnt_q[0] !== 0) begin tests_failed++; $display("FAIL single_grant_id got %0d exp 0", gnt_q[0]); end
         for (int k = 0; k < 4; k++) begin
            ea = AW'(32'h010 + k);
            tests_run++; if (addr_log[g+1+k] !== ea) begin tests_failed++; $display("FAIL single_addr%0d got %h exp %h", k, addr_log[g+1+k], ea); end
         end
         tests_run++; if (beat_data.size() !== 4) begin tests_failed++; $display("FAIL single_beats got %0d exp 4", beat_data.size()); end
         if (beat_data.size() == 4) begin
            tests_run++; if (beat_cyc[0] !== g + 3) begin tests_failed++; $display("FAIL single_latency got %0d exp %0d", beat_cyc[0], g + 3); end
            for (int k = 0; k < 4; k++) begin
               ea = AW'(32'h010 + k);
               tests_run++; if (beat_data[k] !== rom_f(ea)) begin tests_failed++; $display("FAIL single_data%0d got %h exp %h", k, beat_data[k], rom_f(ea)); end
               tests_run++; if (beat_id[k] !== 2'd0) begin tests_failed++; $display("FAIL single_id%0d got %0d exp 0", k, beat_id[k]); end
               tests_run++; if (beat_last[k] !== (k == 3)) begin tests_failed++; $display("FAIL single_last%0d got %b exp %b", k, beat_last[k], (k == 3)); end
            end
         end
      end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_end got %b exp 0", busy); end
   endtask

   task automatic test_round_robin();
      logic [AW-1:0] ea;
      do_reset();
      clear_logs();
      for (int i = 0; i < NR; i++) set_req(i, AW'(32'h100 + 16 * i), 8'd2);
      repeat (40) step();
      tests_run++; if (gnt_q.size() !== 4) begin tests_failed++; $display("FAIL rr_grants got %0d exp 4", gnt_q.size()); end
      if (gnt_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            tests_run++; if (gnt_q[i] !== i) begin tests_failed++; $display("FAIL rr_order%0d got %0d exp %0d", i, gnt_q[i], i); end
            if (i > 0) begin
               tests_run++; if (gnt_cyc[i] - gnt_cyc[i-1] !== 5) begin tests_failed++; $display("FAIL rr_gap%0d got %0d exp 5", i, gnt_cyc[i] - gnt_cyc[i-1]); end
            end
         end
      end
      tests_run++; if (beat_data.size() !== 8) begin tests_failed++; $display("FAIL rr_beats got %0d exp 8", beat_data.size()); end
      if (beat_data.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            ea = AW'(32'h100 + 16 * (k / 2) + (k % 2));
            tests_run++; if (beat_id[k] !== IW'(k / 2)) begin tests_failed++; $display("FAIL rr_id%0d got %0d exp %0d", k, beat_id[k], k / 2); end
            tests_run++; if (beat_last[k] !== (k % 2 == 1)) begin tests_failed++; $display("FAIL rr_last%0d got %b exp %b", k, beat_last[k], (k % 2 == 1)); end
            tests_run++; if (beat_data[k] !== rom_f(ea)) begin tests_failed++; $display("FAIL rr_data%0d got %h exp %h", k, beat_data[k], rom_f(ea)); end
         end
      end
   endtask

   task automatic test_rotation();
      clear_logs();
      set_req(2, 10'h200, 8'd1);
      step();
      set_req(0, 10'h080, 8'd1);
      repeat (12) step();
      set_req(0, 10'h081, 8'd1);
      set_req(1, 10'h090, 8'd1);
      repeat (14) step();
      tests_run++; if (gnt_q.size() !== 4) begin tests_failed++; $display("FAIL rot_grants got %0d exp 4", gnt_q.size()); end
      if (gnt_q.size() == 4) begin
         tests_run++; if (gnt_q[0] !== 2) begin tests_failed++; $display("FAIL rot_order0 got %0d exp 2", gnt_q[0]); end
         tests_run++; if (gnt_q[1] !== 0) begin tests_failed++; $display("FAIL rot_order1 got %0d exp 0", gnt_q[1]); end
         tests_run++; if (gnt_q[2] !== 1) begin tests_failed++; $display("FAIL rot_order2 got %0d exp 1", gnt_q[2]); end
         tests_run++; if (gnt_q[3] !== 0) begin tests_failed++; $display("FAIL rot_order3 got %0d exp 0", gnt_q[3]); end
      end
   endtask

   task automatic test_len_zero();
      clear_logs();
      set_req(1, 10'h055, 8'd0);
      repeat (8) step();
      tests_run++; if (gnt_q.size() !== 1) begin tests_failed++; $display("FAIL len0_ready_pulses got %0d exp 1", gnt_q.size()); end
      if (gnt_q.size() == 1) begin
         tests_run++; if (gnt_q[0] !== 1) begin tests_failed++; $display("FAIL len0_grant_id got %0d exp 1", gnt_q[0]); end
      end
      tests_run++; if (beat_data.size() !== 0) begin tests_failed++; $display("FAIL len0_beats got %0d exp 0", beat_data.size()); end
      tests_run++; if (busy_cnt < 1 || busy_cnt > 2) begin tests_failed++; $display("FAIL len0_busy_cycles got %0d exp 1..2", busy_cnt); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL len0_busy_end got %b exp 0", busy); end
   endtask

   task automatic test_wrap();
      int g;
      logic [AW-1:0] ea;
      clear_logs();
      set_req(2, 10'h3FE, 8'd4);
      repeat (14) step();
      tests_run++; if (gnt_q.size() !== 1) begin tests_failed++; $display("FAIL wrap_grants got %0d exp 1", gnt_q.size()); end
      if (gnt_q.size() == 1) begin
         g = gnt_cyc[0];
         for (int k = 0; k < 4; k++) begin
            ea = AW'(32'h3FE + k);
            tests_run++; if (addr_log[g+1+k] !== ea) begin tests_failed++; $display("FAIL wrap_addr%0d got %h exp %h", k, addr_log[g+1+k], ea); end
         end
`ifdef WEIGHT_FETCH_WRAP_ERR_EN
         tests_run++; if (wrap_log[g] !== 1'b0) begin tests_failed++; $display("FAIL wrap_err_in_grant got %b exp 0", wrap_log[g]); end
         tests_run++; if (wrap_log[g+1] !== 1'b1) begin tests_failed++; $display("FAIL wrap_err_after_grant got %b exp 1", wrap_log[g+1]); end
`endif
      end
      tests_run++; if (beat_data.size() !== 4) begin tests_failed++; $display("FAIL wrap_beats got %0d exp 4", beat_data.size()); end
      if (beat_data.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            ea = AW'(32'h3FE + k);
            tests_run++; if (beat_data[k] !== rom_f(ea)) begin tests_failed++; $display("FAIL wrap_data%0d got %h exp %h", k, beat_data[k], rom_f(ea)); end
         end
         tests_run++; if (beat_last[3] !== 1'b1) begin tests_failed++; $display("FAIL wrap_last got %b exp 1", beat_last[3]); end
      end
   endtask

   task automatic test_reset_mid();
      int c0;
      logic [AW-1:0] ea;
      clear_logs();
      set_req(1, 10'h100, 8'd8);
      for (int n = 0; n < 30 && beat_data.size() < 3; n++) step();
      tests_run++; if (beat_data.size() !== 3) begin tests_failed++; $display("FAIL rstmid_reach_beat3 got %0d exp 3", beat_data.size()); end
      rst_n = 1'b0;
      #1;
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rsp_valid got %b exp 0", rsp_valid); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b exp 0", busy); end
      tests_run++; if (rsp_last !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rsp_last got %b exp 0", rsp_last); end
      tests_run++; if (rom_addr !== '0) begin tests_failed++; $display("FAIL rstmid_rom_addr got %h exp 0", rom_addr); end
`ifdef WEIGHT_FETCH_WRAP_ERR_EN
      tests_run++; if (wrap_err !== 1'b0) begin tests_failed++; $display("FAIL rstmid_wrap_err got %b exp 0", wrap_err); end
`endif
      @(negedge clk);
      clear_logs();
      req_valid = '0;
      set_req(3, 10'h020, 8'd2);
      rst_n = 1'b1;
      c0 = cyc;
      repeat (10) step();
      tests_run++; if (gnt_q.size() !== 1) begin tests_failed++; $display("FAIL rstmid_grants got %0d exp 1", gnt_q.size()); end
      if (gnt_q.size() == 1) begin
         tests_run++; if (gnt_q[0] !== 3) begin tests_failed++; $display("FAIL rstmid_grant_id got %0d exp 3", gnt_q[0]); end
         tests_run++; if (gnt_cyc[0] !== c0 + 1) begin tests_failed++; $display("FAIL rstmid_grant_cycle got %0d exp %0d", gnt_cyc[0], c0 + 1); end
      end
      tests_run++; if (beat_data.size() !== 2) begin tests_failed++; $display("FAIL rstmid_beats got %0d exp 2", beat_data.size()); end
      if (beat_data.size() == 2) begin
         for (int k = 0; k < 2; k++) begin
            ea = AW'(32'h020 + k);
            tests_run++; if (beat_id[k] !== 2'd3) begin tests_failed++; $display("FAIL rstmid_id%0d got %0d exp 3", k, beat_id[k]); end
            tests_run++; if (beat_data[k] !== rom_f(ea)) begin tests_failed++; $display("FAIL rstmid_data%0d got %h exp %h", k, beat_data[k], rom_f(ea)); end
            tests_run++; if (beat_last[k] !== (k == 1)) begin tests_failed++; $display("FAIL rstmid_last%0d got %b exp %b", k, beat_last[k], (k == 1)); end
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_base  = '0;
      req_len   = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_rotation();
      test_len_zero();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
